// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, widths,
// latched-request payload and a constant clog2 helper.
package dmem_responder_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } dmemState_t;

  // Request captured at accept; the port is not looked at again until IDLE.
  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [WORD_BYTES-1:0] byteEn;
    logic                  isRead;
    logic                  isWrite;
  } dmemReq_t;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core load/store port bundle.
//   master: core side (drives requests, receives completion)
//   slave : responder side
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic                  MemRead;
  logic                  MemWrite;
  logic [ADDR_W-1:0]     dAddress;
  logic [DATA_W-1:0]     dWriteData;
  logic [WORD_BYTES-1:0] byteEn;
  logic [DATA_W-1:0]     dReadData;
  logic                  memReady;
  logic                  memErr;

  modport master (
    output MemRead, MemWrite, dAddress, dWriteData, byteEn,
    input  dReadData, memReady, memErr
  );

  modport slave (
    input  MemRead, MemWrite, dAddress, dWriteData, byteEn,
    output dReadData, memReady, memErr
  );
endinterface

// File: rtl/dmem_byte_merge.sv
// Combinational lane merge: each enabled byte lane takes newWord, others keep oldWord.
//   oldWord    in  32  current storage word
//   newWord    in  32  store data
//   byteEn     in  4   lane enables, bit i covers bits [8i+7:8i]
//   mergedWord out 32  word to write back
module dmem_byte_merge
  import dmem_responder_pkg::*;
(
  input  logic [DATA_W-1:0]     oldWord,
  input  logic [DATA_W-1:0]     newWord,
  input  logic [WORD_BYTES-1:0] byteEn,
  output logic [DATA_W-1:0]     mergedWord
);

  always_comb begin
    mergedWord = oldWord;
    for (int i = 0; i < int'(WORD_BYTES); i++) begin
      if (byteEn[i]) mergedWord[8*i +: 8] = newWord[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the multicycle core: word storage with programmable
// wait states, one-cycle completion pulse and error reporting.
//   clk  in  rising-edge clock
//   rst  in  asynchronous reset, active-low
//   bus  slave modport: MemRead/MemWrite/dAddress/dWriteData/byteEn in,
//        dReadData/memReady/memErr out (all registered)
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 256,
  parameter int unsigned       WAIT_STATES = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned       IDX_W = clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH_WORDS * WORD_BYTES);

  dmemState_t        state;
  logic [CNT_W-1:0]  waitCnt;
  dmemReq_t          req;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  wordIdx;
  logic              accessErr;
  logic              doAccess;
  logic [DATA_W-1:0] mergedWord;

  // Offset wraps high for addresses below BASE_ADDR, so one compare covers both ends.
  assign offset    = req.addr - BASE_ADDR;
  assign wordIdx   = offset[IDX_W+1:2];
  assign accessErr = (req.addr[1:0] != 2'b00) || (offset >= SPAN) ||
                     (req.isRead && req.isWrite);
  assign doAccess  = (state == S_BUSY) && (waitCnt == '0);

  dmem_byte_merge uMerge (
    .oldWord    (mem[wordIdx]),
    .newWord    (req.wdata),
    .byteEn     (req.byteEn),
    .mergedWord (mergedWord)
  );

  // Storage is not reset; a reset clears state, which gates doAccess off.
  always_ff @(posedge clk) begin
    if (doAccess && req.isWrite && !accessErr) mem[wordIdx] <= mergedWord;
  end

  // Control FSM with registered completion outputs.
  // Every request passes through BUSY so the access edge is always WAIT_STATES+1
  // edges after accept, including WAIT_STATES=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      waitCnt       <= '0;
      req           <= '0;
      bus.dReadData <= '0;
      bus.memReady  <= 1'b0;
      bus.memErr    <= 1'b0;
    end else begin
      bus.memReady <= 1'b0;
      bus.memErr   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.MemRead || bus.MemWrite) begin
            req <= '{addr:    bus.dAddress,
                     wdata:   bus.dWriteData,
                     byteEn:  bus.byteEn,
                     isRead:  bus.MemRead,
                     isWrite: bus.MemWrite};
            waitCnt <= CNT_W'(WAIT_STATES);
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (waitCnt == '0) begin
            state        <= S_DONE;
            bus.memReady <= 1'b1;
            bus.memErr   <= accessErr;
            if (accessErr) bus.dReadData <= '0;
            else if (req.isRead) bus.dReadData <= mem[wordIdx];
          end else begin
            waitCnt <= waitCnt - CNT_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_STATES=2 and 0 instances).
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_responder_if busA ();
  dmem_responder_if busB ();

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dutA (
    .clk (clk), .rst (rst), .bus (busA.slave)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dutB (
    .clk (clk), .rst (rst), .bus (busB.slave)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit useB, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    if (useB) begin
      busB.MemRead = rd; busB.MemWrite = wr; busB.dAddress = addr;
      busB.dWriteData = data; busB.byteEn = be;
    end else begin
      busA.MemRead = rd; busA.MemWrite = wr; busA.dAddress = addr;
      busA.dWriteData = data; busA.byteEn = be;
    end
  endtask

  // One request; lat = edges from accept to memReady seen, -1 on timeout.
  task automatic access(input bit useB, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                        output int lat, output logic [31:0] rdata, output logic err);
    @(negedge clk);
    drive(useB, rd, wr, addr, data, be);
    @(posedge clk);
    #1;
    drive(useB, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    lat = -1; rdata = 32'h0; err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (useB ? busB.memReady : busA.memReady) begin
        lat   = i;
        rdata = useB ? busB.dReadData : busA.dReadData;
        err   = useB ? busB.memErr : busA.memErr;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  int          lat;
  logic [31:0] rdata;
  logic        err;
  bit          seen;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkEq("rstReadData", busA.dReadData, 32'h0);
    checkEq("rstReady", 32'(busA.memReady), 32'h0);
    checkEq("rstErr", 32'(busA.memErr), 32'h0);

    // full-word store and load
    access(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rdata, err);
    checkEq("st10Lat", 32'(lat), 32'd3);
    checkEq("st10Err", 32'(err), 32'h0);
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, lat, rdata, err);
    checkEq("ld10Lat", 32'(lat), 32'd3);
    checkEq("ld10Data", rdata, 32'hDEADBEEF);
    checkEq("ld10Err", 32'(err), 32'h0);

    // single-lane store; read ignores byteEn
    access(1'b0, 1'b0, 1'b1, 32'h10, 32'h000000AA, 4'h1, lat, rdata, err);
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rdata, err);
    checkEq("lanes10Data", rdata, 32'hDEADBEAA);

    // error completions
    access(1'b0, 1'b1, 1'b0, 32'h12, 32'h0, 4'hF, lat, rdata, err);
    checkEq("misLat", 32'(lat), 32'd3);
    checkEq("misErr", 32'(err), 32'h1);
    checkEq("misData", rdata, 32'h0);
    access(1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF, lat, rdata, err);
    checkEq("oorErr", 32'(err), 32'h1);
    checkEq("oorData", rdata, 32'h0);
    access(1'b0, 1'b0, 1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, lat, rdata, err);
    checkEq("misStErr", 32'(err), 32'h1);
    access(1'b0, 1'b0, 1'b1, 32'h404, 32'hFFFFFFFF, 4'hF, lat, rdata, err);
    checkEq("oorStErr", 32'(err), 32'h1);
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, lat, rdata, err);
    checkEq("after10Data", rdata, 32'hDEADBEAA);
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, lat, rdata, err);
    checkEq("wrap0Err", 32'(err), 32'h0);

    // both strobes -> error, no write
    access(1'b0, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, lat, rdata, err);
    access(1'b0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, lat, rdata, err);
    checkEq("bothErr", 32'(err), 32'h1);
    checkEq("bothData", rdata, 32'h0);
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, lat, rdata, err);
    checkEq("ld20Data", rdata, 32'h11223344);

    // empty byteEn writes nothing; dReadData held across a store
    access(1'b0, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, lat, rdata, err);
    checkEq("be0Err", 32'(err), 32'h0);
    checkEq("be0Hold", rdata, 32'h11223344);
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, lat, rdata, err);
    checkEq("be0Data", rdata, 32'h11223344);

    // reset in BUSY abandons the store
    access(1'b0, 1'b0, 1'b1, 32'h30, 32'h0BADF00D, 4'hF, lat, rdata, err);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h30, 32'h12345678, 4'hF);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (busA.memReady) seen = 1'b1;
    end
    checkEq("rstNoReady", 32'(seen), 32'h0);
    checkEq("rstMidData", busA.dReadData, 32'h0);
    access(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 4'hF, lat, rdata, err);
    checkEq("ld30Data", rdata, 32'h0BADF00D);

    // zero wait states
    access(1'b1, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, lat, rdata, err);
    checkEq("ws0StLat", 32'(lat), 32'd1);
    access(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, lat, rdata, err);
    checkEq("ws0LdLat", 32'(lat), 32'd1);
    checkEq("ws0LdData", rdata, 32'hCAFEF00D);
    checkEq("ws0LdErr", 32'(err), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
